// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge: one APB SETUP/ACCESS per accepted AHB transfer, UART at 0x000-0x3FF, TIMER at 0x400-0x7FF.
// Latency: zero-wait APB returns bridge_ready at cycle 3 after accept; each APB wait state adds a cycle.
// Backpressure: bridge_ready low while busy, no queueing; optional ACCESS timeout under APB_TIMEOUT_EN.
module ahb_apb_bridge #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              bridge_enable,
  input  logic [ADDR_W-1:0] bridge_addr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              bridge_ready,
  output logic              hresp,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel_uart,
  output logic              psel_timer,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata_uart,
  input  logic [DATA_W-1:0] prdata_timer,
  input  logic              pready_uart,
  input  logic              pready_timer,
  input  logic              pslverr
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_hrdata;
  logic              w_accept;
  logic              w_unmapped;
  logic              w_sel_timer;
  logic              w_pready;
  logic [DATA_W-1:0] w_prdata;
  logic              w_timeout;
  logic              w_unused;

  // htrans[0] only distinguishes NONSEQ from SEQ, which the bridge treats alike
  assign w_unused    = htrans[0];

  assign w_accept    = (r_state == S_IDLE) & bridge_enable & htrans[1] & bridge_ready;
  assign w_unmapped  = bridge_addr[ADDR_W-1];
  assign w_sel_timer = r_addr[ADDR_W-2];
  assign w_pready    = w_sel_timer ? pready_timer : pready_uart;
  assign w_prdata    = w_sel_timer ? prdata_timer : prdata_uart;

`ifdef APB_TIMEOUT_EN
  logic [4:0] r_cnt;

  // ACCESS cycle counter, restarted for every accepted transfer
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                r_cnt <= '0;
    else if (w_accept)           r_cnt <= '0;
    else if (r_state == S_ACCESS) r_cnt <= r_cnt + 5'd1;
  end

  // last permitted ACCESS cycle; pready in this same cycle still completes normally
  assign w_timeout = (r_cnt == 5'(TIMEOUT_CYCLES - 1));
`else
  // no timeout: ACCESS waits for pready indefinitely (expression is constant false)
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // state register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_unmapped ? S_ERR1 : S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: begin
        if (w_pready)       w_next = pslverr ? S_ERR1 : S_IDLE;
        else if (w_timeout) w_next = S_ERR1;
      end
      S_ERR1:   w_next = S_ERR2;
      S_ERR2:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // outputs decoded from state; pwdata passes hwdata through during SETUP
  always_comb begin
    psel_uart    = ((r_state == S_SETUP) | (r_state == S_ACCESS)) & ~w_sel_timer;
    psel_timer   = ((r_state == S_SETUP) | (r_state == S_ACCESS)) &  w_sel_timer;
    penable      = (r_state == S_ACCESS);
    bridge_ready = (r_state == S_IDLE) | (r_state == S_ERR2);
    hresp        = (r_state == S_ERR1) | (r_state == S_ERR2);
    pwdata       = (r_state == S_SETUP) ? hwdata : r_pwdata;
    paddr        = r_addr;
    pwrite       = r_write;
    hrdata       = r_hrdata;
  end

  // address-phase capture on accept, data-phase capture in SETUP
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_pwdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= bridge_addr;
        r_write <= hwrite;
      end
      if (r_state == S_SETUP) r_pwdata <= hwdata;
    end
  end

  // read data updates only on an error-free read completion
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      r_hrdata <= '0;
    else if ((r_state == S_ACCESS) & w_pready & ~pslverr & ~r_write)
      r_hrdata <= w_prdata;
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: reset, UART write, TIMER read with waits,
// slave error, unmapped access, optional timeout, asynchronous reset mid-ACCESS.
module tb_ahb_apb_bridge;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        bridge_enable;
  logic [11:0] bridge_addr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        bridge_ready;
  logic        hresp;
  logic [11:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel_uart;
  logic        psel_timer;
  logic        penable;
  logic [31:0] prdata_uart;
  logic [31:0] prdata_timer;
  logic        pready_uart;
  logic        pready_timer;
  logic        pslverr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 hclk = ~hclk;

  ahb_apb_bridge dut (
    .hclk(hclk), .hresetn(hresetn), .bridge_enable(bridge_enable), .bridge_addr(bridge_addr),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
    .bridge_ready(bridge_ready), .hresp(hresp), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .psel_uart(psel_uart), .psel_timer(psel_timer), .penable(penable),
    .prdata_uart(prdata_uart), .prdata_timer(prdata_timer),
    .pready_uart(pready_uart), .pready_timer(pready_timer), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // advance to the next cycle, away from the edge
  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic present(input logic [11:0] a, input logic wr);
    bridge_enable = 1'b1;
    htrans        = 2'b10;
    bridge_addr   = a;
    hwrite        = wr;
  endtask

  task automatic drop();
    bridge_enable = 1'b0;
    htrans        = 2'b00;
  endtask

  initial begin
    hresetn = 1'b0; bridge_enable = 1'b0; bridge_addr = '0; htrans = '0; hwrite = 1'b0;
    hwdata = '0; prdata_uart = '0; prdata_timer = '0; pready_uart = 1'b0; pready_timer = 1'b0;
    pslverr = 1'b0;

    // reset values
    #3;
    chk("rst_ready", bridge_ready, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_psel", {psel_uart, psel_timer, penable}, 0);
    #9 hresetn = 1'b1;

    // write UART 0x004, zero wait
    tick();
    present(12'h004, 1'b1); pready_uart = 1'b1;
    #1 chk("w1_c0_ready", bridge_ready, 1);
    tick(); drop(); hwdata = 32'hDEADBEEF;
    #1 chk("w1_c1_psel", {psel_uart, psel_timer, penable}, 3'b100);
    chk("w1_c1_ready", bridge_ready, 0);
    chk("w1_c1_paddr", paddr, 32'h004);
    chk("w1_c1_pwrite", pwrite, 1);
    chk("w1_c1_pwdata", pwdata, 32'hDEADBEEF);
    tick(); hwdata = 32'h0;
    #1 chk("w1_c2_psel", {psel_uart, psel_timer, penable}, 3'b101);
    chk("w1_c2_pwdata", pwdata, 32'hDEADBEEF);
    chk("w1_c2_ready", bridge_ready, 0);
    tick();
    #1 chk("w1_c3_ready", bridge_ready, 1);
    chk("w1_c3_hresp", hresp, 0);
    chk("w1_c3_psel", {psel_uart, psel_timer, penable}, 3'b000);
    chk("w1_c3_hrdata", hrdata, 0);

    // read TIMER 0x408, three wait states; UART signals active but must be ignored
    tick();
    present(12'h408, 1'b0); pready_timer = 1'b0; pready_uart = 1'b1;
    prdata_uart = 32'hBAD0BAD0; prdata_timer = 32'hFFFFFFFF;
    #1 chk("r1_c0_ready", bridge_ready, 1);
    tick();
    #1 chk("r1_c1_psel", {psel_uart, psel_timer, penable}, 3'b010);
    chk("r1_c1_paddr", paddr, 32'h408);
    chk("r1_c1_pwrite", pwrite, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 chk("r1_wait_psel", {psel_uart, psel_timer, penable}, 3'b011);
      chk("r1_wait_ready", bridge_ready, 0);
    end
    tick(); pready_timer = 1'b1; prdata_timer = 32'h00001234;
    #1 chk("r1_c5_psel", {psel_uart, psel_timer, penable}, 3'b011);
    tick(); drop(); pready_timer = 1'b0;
    #1 chk("r1_c6_ready", bridge_ready, 1);
    chk("r1_c6_hrdata", hrdata, 32'h00001234);
    chk("r1_c6_psel", {psel_uart, psel_timer, penable}, 3'b000);
    tick();
    #1 chk("r1_noqueue", {psel_uart, psel_timer, penable}, 3'b000);
    chk("r1_c7_ready", bridge_ready, 1);

    // write UART 0x010 with slave error
    present(12'h010, 1'b1);
    tick(); drop(); hwdata = 32'h55;
    #1 chk("e1_c1_psel", {psel_uart, psel_timer, penable}, 3'b100);
    tick(); pslverr = 1'b1; pready_uart = 1'b1;
    #1 chk("e1_c2_penable", penable, 1);
    tick(); pslverr = 1'b0;
    #1 chk("e1_err1", {bridge_ready, hresp}, 2'b01);
    chk("e1_err1_psel", {psel_uart, psel_timer, penable}, 3'b000);
    tick();
    #1 chk("e1_err2", {bridge_ready, hresp}, 2'b11);
    tick();
    #1 chk("e1_idle", {bridge_ready, hresp}, 2'b10);
    chk("e1_hrdata", hrdata, 32'h00001234);

    // unmapped 0x900
    present(12'h900, 1'b0);
    tick(); drop();
    #1 chk("u1_err1", {bridge_ready, hresp}, 2'b01);
    chk("u1_err1_psel", {psel_uart, psel_timer, penable}, 3'b000);
    tick();
    #1 chk("u1_err2", {bridge_ready, hresp}, 2'b11);
    chk("u1_err2_psel", {psel_uart, psel_timer, penable}, 3'b000);
    tick();
    #1 chk("u1_idle", {bridge_ready, hresp}, 2'b10);
    chk("u1_hrdata", hrdata, 32'h00001234);

`ifdef APB_TIMEOUT_EN
    // UART never ready: 16 ACCESS cycles then error
    pready_uart = 1'b0;
    present(12'h020, 1'b1);
    tick(); drop();
    #1 chk("t1_setup", {psel_uart, psel_timer, penable}, 3'b100);
    for (int i = 0; i < 16; i++) begin
      tick();
      #1 chk("t1_access", {psel_uart, psel_timer, penable}, 3'b101);
    end
    tick();
    #1 chk("t1_err1", {bridge_ready, hresp}, 2'b01);
    chk("t1_err1_psel", {psel_uart, psel_timer, penable}, 3'b000);
    tick();
    #1 chk("t1_err2", {bridge_ready, hresp}, 2'b11);
    tick();
    #1 chk("t1_idle", {bridge_ready, hresp}, 2'b10);
`endif

    // asynchronous reset while stalled in ACCESS
    pready_uart = 1'b0;
    present(12'h030, 1'b1);
    tick(); drop(); hwdata = 32'hA5A5A5A5;
    tick();
    #1 chk("x1_access", {psel_uart, psel_timer, penable}, 3'b101);
    tick();
    #1 chk("x1_access2", {psel_uart, psel_timer, penable}, 3'b101);
    hresetn = 1'b0;
    #1 chk("x1_rst_psel", {psel_uart, psel_timer, penable}, 3'b000);
    chk("x1_rst_ready", {bridge_ready, hresp}, 2'b10);
    chk("x1_rst_paddr", paddr, 0);
    chk("x1_rst_pwdata", pwdata, 0);
    chk("x1_rst_hrdata", hrdata, 0);
    #1 hresetn = 1'b1;

    // normal write after reset release
    pready_uart = 1'b1;
    tick();
    present(12'h00C, 1'b1);
    tick(); drop(); hwdata = 32'hCAFEF00D;
    #1 chk("w2_c1_psel", {psel_uart, psel_timer, penable}, 3'b100);
    chk("w2_c1_paddr", paddr, 32'h00C);
    tick(); hwdata = 32'h0;
    #1 chk("w2_c2_psel", {psel_uart, psel_timer, penable}, 3'b101);
    chk("w2_c2_pwdata", pwdata, 32'hCAFEF00D);
    tick();
    #1 chk("w2_c3_ready", {bridge_ready, hresp}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
